// File: rtl/axi4_ring_writer_ctrl.sv
// AXI4 ring-buffer writer: FIFOs a sample stream and issues fixed INCR bursts into a DDR ring.
// Ports: aclk/areset (async high), enable/base_addr/buf_len run config, s_* sample stream,
// m_axi_aw*/w*/b* AXI4 write master, wr_ptr (byte offset after last burst), error.
// Optional macro BRESP_CHECK_EN: non-OKAY bresp sets sticky error and halts new bursts.
module axi4_ring_writer_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    enable,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH-1:0]   buf_len,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   wr_ptr,
    output logic                    error
);

    localparam int BB = BURST_LEN * DATA_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]           rd_idx_q, wr_idx_q;
    logic [CW-1:0]           count_q;
    logic                    push, pop;
    logic                    en_arm_q, latch, go, halt;
    logic [ADDR_WIDTH-1:0]   base_q, len_q;
    logic [ADDR_WIDTH-1:0]   offset_q, offset_d, next_off;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]              beat_q, beat_d;

`ifdef BRESP_CHECK_EN
    logic err_q, err_d;
    // one flag serves as both the sticky error and the burst halt
    assign halt  = err_q;
    assign error = err_q;
`else
    logic unused_bresp;
    assign unused_bresp = &{1'b0, m_axi_bresp};
    assign halt  = 1'b0;
    assign error = 1'b0;
`endif

    assign push = s_tvalid && s_tready;
    assign pop  = m_axi_wvalid && m_axi_wready;

    // en_arm_q marks that the current enable-high period has already latched config
    assign latch = (state_q == IDLE) && enable && !en_arm_q;
    assign go    = (state_q == IDLE) && enable && en_arm_q
                   && (count_q >= CW'(BURST_LEN)) && !halt;

    assign next_off = offset_q + ADDR_WIDTH'(BB);

    assign s_tready      = !areset && (count_q != CW'(FIFO_DEPTH));
    assign m_axi_awaddr  = base_q + offset_q;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = mem_q[rd_idx_q];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_q == DATA) && (beat_q == 8'(BURST_LEN - 1));
    assign wr_ptr        = wr_ptr_q;

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        wr_ptr_d      = wr_ptr_q;
        beat_d        = beat_q;
`ifdef BRESP_CHECK_EN
        err_d         = err_q;
`endif
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        if (latch) begin
            offset_d = '0;
            wr_ptr_d = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (go) state_d = ADDR;
            end
            ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                m_axi_wvalid = 1'b1;
                if (m_axi_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (m_axi_wlast) state_d = RESP;
                end
            end
            RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_d = IDLE;
`ifdef BRESP_CHECK_EN
                    if (m_axi_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        offset_d = (next_off == len_q) ? '0 : next_off;
                        wr_ptr_d = (next_off == len_q) ? '0 : next_off;
                    end
`else
                    offset_d = (next_off == len_q) ? '0 : next_off;
                    wr_ptr_d = (next_off == len_q) ? '0 : next_off;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            offset_q <= '0;
            wr_ptr_q <= '0;
            beat_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            en_arm_q <= 1'b0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            count_q  <= '0;
`ifdef BRESP_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            wr_ptr_q <= wr_ptr_d;
            beat_q   <= beat_d;
`ifdef BRESP_CHECK_EN
            err_q    <= err_d;
`endif
            if (!enable) en_arm_q <= 1'b0;
            else if (latch) en_arm_q <= 1'b1;
            if (latch) begin
                base_q <= base_addr;
                len_q  <= buf_len;
            end
            if (push) wr_idx_q <= wr_idx_q + 1'b1;
            if (pop)  rd_idx_q <= rd_idx_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_idx_q] <= s_tdata;
    end

endmodule

// File: doc/axi4_ring_writer_ctrl.md
Name: axi4_ring_writer_ctrl

Overview:
- Sequences the AXI4 master write datapath from the sample stream into a DDR ring buffer.
- Buffers incoming samples in an internal FIFO and issues fixed-length INCR write bursts to base_addr + offset.
- The offset wraps at buf_len. Exposes a write pointer so software knows which region of the buffer is valid.

Parameters:
DATA_WIDTH, 32, sample/AXI data width in bits (32 or 64)
ADDR_WIDTH, 32, AXI address width
BURST_LEN, 16, beats per burst (power of 2, 1..256)
FIFO_DEPTH, 64, internal sample FIFO depth (power of 2, >= 2*BURST_LEN)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
enable  in  1  run control; rising edge latches base_addr/buf_len and clears offset
base_addr  in  ADDR_WIDTH  ring buffer start, burst-byte aligned
buf_len  in  ADDR_WIDTH  ring size in bytes, nonzero multiple of burst bytes
s_tdata  in  DATA_WIDTH  sample data
s_tvalid  in  1  sample valid
s_tready  out  1  FIFO not full
m_axi_awaddr  out  ADDR_WIDTH  burst address
m_axi_awlen  out  8  BURST_LEN-1
m_axi_awsize  out  3  log2(DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  DATA_WIDTH  FIFO head
m_axi_wstrb  out  DATA_WIDTH/8  all ones
m_axi_wlast  out  1  final beat of burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready
wr_ptr  out  ADDR_WIDTH  byte offset after last completed burst
error  out  1  sticky response error (BRESP_CHECK_EN only)

Behaviour:
- Reset values (async, immediate):
  - awvalid, wvalid, wlast, bready, error = 0.
  - wr_ptr and offset = 0; FIFO empty; s_tready = 0 while areset is high.
  - State = IDLE.
- FIFO:
  - Push on s_tvalid && s_tready.
  - Pop on wvalid && wready.
  - Simultaneous push and pop at full or empty is legal; count is unchanged.
- Burst bytes: BB = BURST_LEN*DATA_WIDTH/8.
- Latching: on the enable 0->1 edge, detected in IDLE, latch base_addr and buf_len, and set offset and wr_ptr to 0.
- FSM:
  - IDLE: go to ADDR when enable && fifo_count >= BURST_LEN && !halt.
  - ADDR: awvalid=1, awaddr=base+offset. On awready go to DATA.
    - Address and data are serialised: wvalid is never high before AW is accepted.
  - DATA: wvalid=1 while beats remain. Beat counter counts from 0; wlast=1 when count==BURST_LEN-1. On wlast && wready go to RESP.
    - The FIFO is guaranteed non-empty here because the burst starts only with >= BURST_LEN entries.
  - RESP: bready=1. On bvalid:
    - offset = (offset+BB == buf_len) ? 0 : offset+BB.
    - wr_ptr = new offset, updated in the same cycle as the handshake (visible the next cycle).
    - Return to IDLE.
- awvalid and wvalid hold stable until their handshakes complete (AXI rule).
- Throughput bound: at most one outstanding burst.
- Deasserting enable mid-burst: the burst completes through RESP, then the FSM stays in IDLE.
  - Residual FIFO data (< BURST_LEN) is retained.
  - s_tready still follows FIFO occupancy.
- A new enable edge restarts at offset 0.
- Wrap: the final burst ends exactly at base+buf_len-1. The next burst addresses base+0.
- Bursts never cross a 4 KB boundary, provided base_addr is BB-aligned and BB <= 4096 (integrator constraint).

Optional Feature:
- Macro: BRESP_CHECK_EN.
- With the macro defined:
  - bresp != OKAY at the bvalid handshake sets error = 1 (sticky; cleared only by areset) and sets an internal halt flag.
  - halt blocks new bursts. wr_ptr is not advanced for the failed burst.
- Without the macro: bresp is ignored, error is tied to 0, and halt does not exist.

Test Plan:
- Reset release, enable=1, base=0x1000_0000, buf_len=256, DATA_WIDTH=32, BURST_LEN=16, 40 samples -> two bursts at awaddr 0x1000_0000 and 0x1000_0040, awlen=15, wlast on the 16th beat; wr_ptr=0x80; 8 samples remain in the FIFO.
- Continuous stream of 80 samples into buf_len=256 (4 bursts) -> 5th burst awaddr wraps to 0x1000_0000; wr_ptr sequence 0x40, 0x80, 0xC0, 0x00, 0x40.
- Slave holds wready low for 10 cycles mid-burst and awready random -> data order preserved (incrementing pattern), s_tready=0 once 64 entries are held, no sample lost.
- enable dropped during beat 5 -> burst completes with 16 beats and a B handshake, then awvalid stays 0; re-enable with base=0x2000_0000 -> next awaddr 0x2000_0000.
- areset asserted during DATA -> awvalid/wvalid/bready drop the same cycle, wr_ptr=0, FIFO empty.
- With BRESP_CHECK_EN, bresp=2'b10 on the first burst -> error=1, wr_ptr stays 0, no further AW issued despite a full FIFO.
